mapper_frame_sequencer: RTL

- Symbol-rate controller that sits directly in front of the 16-QAM mapper.
- Builds framed symbol streams: a fixed preamble, then payload nibbles taken from an upstream valid/ready source, with pilot symbols inserted periodically.
- Drives the mapper's 4-bit data input and its ref_level input. ref_level is latched only at frame boundaries, so constellation scale never changes mid-frame.
- Reports underflow, and marks the symbol type for downstream framing and debug taps.

---
 rtl/mapper_frame_sequencer_pkg.sv | 34 +++
 rtl/mapper_frame_sequencer_pilot_scheduler.sv | 61 ++++++
 rtl/mapper_frame_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mapper_frame_sequencer_pkg.sv
// rtl/mapper_frame_sequencer_pkg.sv - shared encodings for the 16-QAM mapper frame sequencer
// Contents: nibble bit-field positions, symbol-type and FSM state enums,
// and a helper that assembles a mapper nibble from its Q and I halves.
package mapper_frame_sequencer_pkg;

    // Mapper nibble layout: Q in the upper pair, I in the lower pair.
    localparam int QUADRATURE_MSB = 3;
    localparam int QUADRATURE_LSB = 2;
    localparam int INPHASE_MSB    = 1;
    localparam int INPHASE_LSB    = 0;

    typedef enum logic [1:0] {
        SYM_IDLE     = 2'd0,
        SYM_PREAMBLE = 2'd1,
        SYM_PILOT    = 2'd2,
        SYM_PAYLOAD  = 2'd3
    } sym_type_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_PILOT    = 2'd3
    } state_t;

    function automatic logic [3:0] pack_sym(input logic [1:0] q, input logic [1:0] i);
        logic [3:0] s;
        s = '0;
        s[QUADRATURE_MSB:QUADRATURE_LSB] = q;
        s[INPHASE_MSB:INPHASE_LSB]       = i;
        return s;
    endfunction

endpackage

// File: rtl/mapper_frame_sequencer_pilot_scheduler.sv
// rtl/mapper_frame_sequencer_pilot_scheduler.sv - payload slot and pilot spacing counters
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   slot_tick       : a payload slot (data or fill) is emitted this cycle
//   pilot_tick      : a pilot symbol is emitted this cycle
//   pilot_due       : a pilot is owed before the next payload slot
//   frame_done      : the slot currently being emitted is the last of the frame
//   pilot_wrap      : the slot currently being emitted completes a pilot period
module mapper_frame_sequencer_pilot_scheduler #(
    parameter int PILOT_PERIOD  = 8,
    parameter int FRAME_PAYLOAD = 64,
    parameter int CNT_W         = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic slot_tick,
    input  logic pilot_tick,
    output logic pilot_due,
    output logic frame_done,
    output logic pilot_wrap
);

    localparam int PW = $clog2(PILOT_PERIOD + 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(FRAME_PAYLOAD - 1);
    localparam logic [PW-1:0]    PILOT_LAST = PW'(PILOT_PERIOD - 1);

    logic [CNT_W-1:0] slot_cnt;
    logic [PW-1:0]    pilot_cnt;

    assign frame_done = (slot_cnt == SLOT_LAST);
    assign pilot_wrap = (pilot_cnt == PILOT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt  <= '0;
            pilot_cnt <= '0;
            pilot_due <= 1'b0;
        end else begin
            if (slot_tick) begin
                if (frame_done) begin
                    // No trailing pilot: the frame ends on its last slot.
                    slot_cnt  <= '0;
                    pilot_cnt <= '0;
                    pilot_due <= 1'b0;
                end else begin
                    slot_cnt <= slot_cnt + 1'b1;
                    if (pilot_wrap) begin
                        pilot_cnt <= '0;
                        pilot_due <= 1'b1;
                    end else begin
                        pilot_cnt <= pilot_cnt + 1'b1;
                    end
                end
            end
            if (pilot_tick) begin
                pilot_due <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mapper_frame_sequencer.sv
// rtl/mapper_frame_sequencer.sv - framed symbol sequencer in front of the 16-QAM mapper
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   clk_en              : symbol strobe, one symbol decided per asserted cycle
//   enable              : start frames back-to-back while high
//   cfg_ref_level       : requested reference level, latched at frame start
//   clr_underflow       : clears the sticky underflow flag
//   in_data/in_valid    : upstream payload nibbles; in_ready marks acceptance
//   sym_data, ref_level : registered mapper inputs
//   sym_active/sym_type : framed-symbol marker and symbol class
//   frame_start         : pulse with the first preamble symbol
//   underflow           : sticky, set whenever a fill symbol is emitted
module mapper_frame_sequencer
    import mapper_frame_sequencer_pkg::*;
#(
    parameter int                  PREAMBLE_LEN  = 16,
    parameter int                  PILOT_PERIOD  = 8,
    parameter int                  FRAME_PAYLOAD = 64,
    parameter logic [3:0]          PILOT_SYM     = 4'b0000,
    parameter logic [3:0]          FILL_SYM      = 4'b0101,
    parameter logic signed [17:0]  REF_DEFAULT   = 18'sd65536
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                enable,
    input  logic signed [17:0]  cfg_ref_level,
    input  logic                clr_underflow,
    input  logic [3:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [3:0]          sym_data,
    output logic signed [17:0]  ref_level,
    output logic                sym_active,
    output logic [1:0]          sym_type,
    output logic                frame_start,
    output logic                underflow
);

    localparam int CNT_MAX = (PREAMBLE_LEN > FRAME_PAYLOAD) ? PREAMBLE_LEN : FRAME_PAYLOAD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);

    state_t           state, state_next;
    sym_type_t        type_q, type_next;
    logic [CNT_W-1:0] pre_cnt, pre_next;
    logic [3:0]       sym_next;
    logic             active_next, start_next, latch_ref, fill;
    logic             slot_tick, pilot_tick, pilot_due, frame_done, pilot_wrap, odd;

    assign in_ready   = clk_en & (state == ST_PAYLOAD) & ~pilot_due;
    assign slot_tick  = clk_en & (state == ST_PAYLOAD);
    assign pilot_tick = clk_en & (state == ST_PILOT);
    assign sym_type   = type_q;
    assign odd        = pre_cnt[0];

    mapper_frame_sequencer_pilot_scheduler #(
        .PILOT_PERIOD  (PILOT_PERIOD),
        .FRAME_PAYLOAD (FRAME_PAYLOAD),
        .CNT_W         (CNT_W)
    ) u_sched (
        .clk        (clk),
        .reset      (reset),
        .slot_tick  (slot_tick),
        .pilot_tick (pilot_tick),
        .pilot_due  (pilot_due),
        .frame_done (frame_done),
        .pilot_wrap (pilot_wrap)
    );

    always_comb begin
        state_next  = state;
        pre_next    = pre_cnt;
        sym_next    = sym_data;
        type_next   = type_q;
        active_next = sym_active;
        start_next  = 1'b0;
        latch_ref   = 1'b0;
        fill        = 1'b0;
        if (clk_en) begin
            case (state)
                ST_IDLE, ST_PREAMBLE: begin
                    // IDLE with enable emits preamble symbol 0 on the same strobe,
                    // so both states share the preamble emission path.
                    if (state == ST_PREAMBLE || enable) begin
                        sym_next    = pack_sym({2{odd}}, {2{odd}});
                        type_next   = SYM_PREAMBLE;
                        active_next = 1'b1;
                        start_next  = (pre_cnt == '0);
                        latch_ref   = (pre_cnt == '0);
                        if (pre_cnt == PRE_LAST) begin
                            state_next = ST_PAYLOAD;
                            pre_next   = '0;
                        end else begin
                            state_next = ST_PREAMBLE;
                            pre_next   = pre_cnt + 1'b1;
                        end
                    end else begin
                        sym_next    = 4'b0000;
                        type_next   = SYM_IDLE;
                        active_next = 1'b0;
                    end
                end
                ST_PAYLOAD: begin
                    type_next   = SYM_PAYLOAD;
                    active_next = 1'b1;
                    if (in_valid && in_ready) begin
                        sym_next = in_data;
                    end else begin
                        sym_next = FILL_SYM;
                        fill     = 1'b1;
                    end
                    // enable is only looked at here, so dropping it mid-frame
                    // lets the current frame run to completion.
                    if (frame_done) begin
                        state_next = enable ? ST_PREAMBLE : ST_IDLE;
                    end else if (pilot_wrap) begin
                        state_next = ST_PILOT;
                    end
                end
                ST_PILOT: begin
                    sym_next    = PILOT_SYM;
                    type_next   = SYM_PILOT;
                    active_next = 1'b1;
                    state_next  = ST_PAYLOAD;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pre_cnt     <= '0;
            sym_data    <= 4'b0000;
            type_q      <= SYM_IDLE;
            sym_active  <= 1'b0;
            frame_start <= 1'b0;
            ref_level   <= REF_DEFAULT;
            underflow   <= 1'b0;
        end else begin
            state       <= state_next;
            pre_cnt     <= pre_next;
            sym_data    <= sym_next;
            type_q      <= type_next;
            sym_active  <= active_next;
            frame_start <= start_next;
            if (latch_ref) begin
                ref_level <= cfg_ref_level;
            end
            // A fill in the same cycle as a clear keeps the flag set.
            if (fill) begin
                underflow <= 1'b1;
            end else if (clr_underflow) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
